// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// HALT exists only when IFETCH_MISALIGN_CHECK_EN is defined.
package ifetch_pkg;

    typedef enum logic [1:0] {
        BUBBLE = 2'd0,
        RUN    = 2'd1
`ifdef IFETCH_MISALIGN_CHECK_EN
        , HALT = 2'd2
`endif
    } fetch_state_t;

    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: PC sequencing, stall/redirect handling and accept counter.
// Optional feature IFETCH_MISALIGN_CHECK_EN: misaligned redirect halts fetch until reset.
module inst_fetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] addr_out,
    input  logic [31:0] rom_data_in,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic [31:0] fetch_count,
    output logic        misalign_err
);

    fetch_state_t state, state_nxt;
    logic [31:0]  fetch_pc, fetch_pc_nxt;
    logic [31:0]  instr_pc_nxt, fetch_count_nxt;
    logic [31:0]  redirect_target;
    logic         stall_hold, accept;

    assign redirect_target = redirect_pc & ALIGN_MASK;
    assign instr_valid     = (state == RUN);
    assign stall_hold      = instr_valid && stall;
    assign accept          = instr_valid && !stall && !redirect;
    // Re-present the held address so the registered ROM keeps returning the same word.
    assign addr_out        = stall_hold ? instr_pc : fetch_pc;
    assign instr_out       = rom_data_in;

`ifdef IFETCH_MISALIGN_CHECK_EN
    logic misalign_q, misalign_nxt;
    logic redirect_misaligned;

    assign redirect_misaligned = |redirect_pc[1:0];
    assign misalign_err        = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_nxt       = state;
        fetch_pc_nxt    = fetch_pc;
        instr_pc_nxt    = instr_pc;
        fetch_count_nxt = accept ? fetch_count + 32'd1 : fetch_count;
`ifdef IFETCH_MISALIGN_CHECK_EN
        misalign_nxt    = misalign_q;
`endif
        case (state)
            BUBBLE, RUN: begin
                if (redirect) begin
`ifdef IFETCH_MISALIGN_CHECK_EN
                    if (redirect_misaligned) begin
                        state_nxt    = HALT;
                        misalign_nxt = 1'b1;
                    end else begin
                        fetch_pc_nxt = redirect_target;
                        state_nxt    = BUBBLE;
                    end
`else
                    fetch_pc_nxt = redirect_target;
                    state_nxt    = BUBBLE;
`endif
                end else if (!stall_hold) begin
                    instr_pc_nxt = fetch_pc;
                    fetch_pc_nxt = fetch_pc + PC_INCR;
                    state_nxt    = RUN;
                end
            end
`ifdef IFETCH_MISALIGN_CHECK_EN
            HALT: begin
            end
`endif
            default: state_nxt = BUBBLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so all updates land together.
        if (reset) begin
            state       <= BUBBLE;
            fetch_pc    <= RESET_PC;
            instr_pc    <= RESET_PC;
            fetch_count <= 32'd0;
`ifdef IFETCH_MISALIGN_CHECK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            fetch_pc    <= fetch_pc_nxt;
            instr_pc    <= instr_pc_nxt;
            fetch_count <= fetch_count_nxt;
`ifdef IFETCH_MISALIGN_CHECK_EN
            misalign_q  <= misalign_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch with a registered ROM model; second instance covers PC wrap.
// Expectations follow IFETCH_MISALIGN_CHECK_EN when it is defined.
module tb_inst_fetch;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] count;
    } acc_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] addr_out, rom_data, instr_out, instr_pc, fetch_count;
    logic        instr_valid, misalign_err;

    logic        b_zero_bit = 1'b0;
    logic [31:0] b_zero_word = 32'd0;
    logic [31:0] b_addr, b_rom_data, b_instr, b_pc, b_count;
    logic        b_valid, b_err;

    logic [31:0] rom [0:63];
    acc_t        sb[$];
    int          tests  = 0;
    int          failed = 0;

    always #5 clock = ~clock;

    inst_fetch dut (
        .clock(clock), .reset(reset), .addr_out(addr_out), .rom_data_in(rom_data),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .fetch_count(fetch_count), .misalign_err(misalign_err)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clock(clock), .reset(reset), .addr_out(b_addr), .rom_data_in(b_rom_data),
        .stall(b_zero_bit), .redirect(b_zero_bit), .redirect_pc(b_zero_word),
        .instr_out(b_instr), .instr_pc(b_pc), .instr_valid(b_valid),
        .fetch_count(b_count), .misalign_err(b_err)
    );

    initial for (int k = 0; k < 64; k++) rom[k] = 32'h1000_0000 + k;

    always @(posedge clock) begin
        if (reset) begin
            rom_data   <= 32'd0;
            b_rom_data <= 32'd0;
        end else begin
            rom_data   <= rom[addr_out[7:2]];
            b_rom_data <= rom[b_addr[7:2]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic s, input logic r, input logic [31:0] rpc);
        @(posedge clock);
        #1;
        reset = rst; stall = s; redirect = r; redirect_pc = rpc;
    endtask

    task automatic expect_acc(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] cnt);
        acc_t e;
        e.pc = pc; e.instr = instr; e.count = cnt;
        sb.push_back(e);
    endtask

    // Monitor: every accepted instruction must match the next scoreboard entry.
    always @(negedge clock) begin
        if (!reset && instr_valid && !stall && !redirect) begin
            if (sb.size() == 0) begin
                check("unexpected_accept_pc", instr_pc, 32'hXXXX_XXXX);
            end else begin
                acc_t e;
                e = sb.pop_front();
                check("acc_pc", instr_pc, e.pc);
                check("acc_instr", instr_out, e.instr);
                check("acc_count", fetch_count, e.count);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_valid", instr_valid, 0);
        check("rst_count", fetch_count, 0);
        check("rst_misalign", misalign_err, 0);
        check("rst_addr", addr_out, 0);
        check("rst_wrap_addr", b_addr, 32'hFFFF_FFF8);

        reset = 1'b0;                                   // first cycle after reset
        @(negedge clock);
        check("c1_valid", instr_valid, 0);
        check("c1_addr", addr_out, 0);
        check("c1_wrap_valid", b_valid, 0);

        drive(0, 0, 0, 0); expect_acc(32'h0, 32'h1000_0000, 0);
        @(negedge clock);
        check("wrap_pc0", b_pc, 32'hFFFF_FFF8);
        check("wrap_instr0", b_instr, 32'h1000_003E);
        drive(0, 0, 0, 0); expect_acc(32'h4, 32'h1000_0001, 1);
        @(negedge clock);
        check("wrap_pc1", b_pc, 32'hFFFF_FFFC);
        check("wrap_instr1", b_instr, 32'h1000_003F);

        for (int i = 0; i < 3; i++) begin              // stall at instr_pc=8
            drive(0, 1, 0, 0);
            @(negedge clock);
            if (i == 0) check("wrap_pc2", b_pc, 32'h0);
            check("stall_valid", instr_valid, 1);
            check("stall_pc", instr_pc, 32'h8);
            check("stall_instr", instr_out, 32'h1000_0002);
            check("stall_addr", addr_out, 32'h8);
            check("stall_count", fetch_count, 2);
        end
        drive(0, 0, 0, 0); expect_acc(32'h8,  32'h1000_0002, 2);
        drive(0, 0, 0, 0); expect_acc(32'hC,  32'h1000_0003, 3);
        drive(0, 0, 0, 0); expect_acc(32'h10, 32'h1000_0004, 4);

        drive(0, 1, 1, 32'h40);                         // redirect wins over stall
        @(negedge clock);
        check("redir_count", fetch_count, 5);
        drive(0, 0, 0, 0);
        @(negedge clock);
        check("bubble_valid", instr_valid, 0);
        check("bubble_addr", addr_out, 32'h40);
        check("bubble_count", fetch_count, 5);
        drive(0, 0, 0, 0); expect_acc(32'h40, 32'h1000_0010, 5);
        drive(0, 0, 0, 0); expect_acc(32'h44, 32'h1000_0011, 6);

        drive(0, 0, 1, 32'h42);                         // misaligned redirect
        @(negedge clock);
        check("mis_redir_count", fetch_count, 7);
`ifdef IFETCH_MISALIGN_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            if (i == 2) drive(0, 0, 1, 32'h80);
            else        drive(0, 0, 0, 0);
            @(negedge clock);
            check("halt_valid", instr_valid, 0);
            check("halt_misalign", misalign_err, 1);
            check("halt_count", fetch_count, 7);
            check("halt_addr", addr_out, 32'h4C);
        end
`else
        drive(0, 0, 0, 0);
        @(negedge clock);
        check("mis_bubble_valid", instr_valid, 0);
        check("mis_bubble_addr", addr_out, 32'h40);
        check("mis_flag", misalign_err, 0);
        drive(0, 0, 0, 0); expect_acc(32'h40, 32'h1000_0010, 7);
        drive(0, 0, 0, 0); expect_acc(32'h44, 32'h1000_0011, 8);
`endif

        drive(1, 0, 0, 0);                              // reset recovers from any state
        drive(0, 0, 0, 0);
        @(negedge clock);
        check("r1_valid", instr_valid, 0);
        check("r1_addr", addr_out, 0);
        check("r1_misalign", misalign_err, 0);
        check("r1_count", fetch_count, 0);
        drive(0, 0, 0, 0); expect_acc(32'h0, 32'h1000_0000, 0);
        drive(0, 0, 1, 32'h20);
        drive(0, 0, 0, 0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clock);
        check("r5_pc", instr_pc, 32'h20);
        check("r5_instr", instr_out, 32'h1000_0008);
        check("r5_count", fetch_count, 1);
        drive(1, 1, 0, 0);                              // reset mid-stall
        drive(0, 0, 0, 0);
        @(negedge clock);
        check("post_rst_valid", instr_valid, 0);
        check("post_rst_count", fetch_count, 0);
        check("post_rst_addr", addr_out, 0);
        drive(0, 0, 0, 0); expect_acc(32'h0, 32'h1000_0000, 0);
        drive(0, 0, 0, 0); expect_acc(32'h4, 32'h1000_0001, 1);

        drive(1, 0, 0, 0);
        @(negedge clock);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
